// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port-per-direction RAM.
// Define RAM_ARBITER_FIXED_PRI_EN for fixed priority (A wins); default is round-robin.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [0:0] OWN_A = 1'b0;
    localparam logic [0:0] OWN_B = 1'b1;

    logic [0:0]            last_grant;
    logic                  rd_pend;
    logic [0:0]            rd_owner;
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;
    logic                  pick_a;

`ifdef RAM_ARBITER_FIXED_PRI_EN
    assign pick_a = 1'b1;
`else
    assign pick_a = (last_grant == OWN_B);
`endif

    // Pick the winner for this cycle; nobody wins while in reset
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (req_a && (!req_b || pick_a)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    // Steer the winner's request onto the RAM, idle values otherwise
    always_comb begin
        ram_we         = 1'b0;
        ram_write_addr = '0;
        ram_read_addr  = '0;
        ram_data       = '0;
        if (gnt_a) begin
            ram_we         = we_a;
            ram_write_addr = addr_a;
            ram_read_addr  = addr_a;
            ram_data       = wdata_a;
        end else if (gnt_b) begin
            ram_we         = we_b;
            ram_write_addr = addr_b;
            ram_read_addr  = addr_b;
            ram_data       = wdata_b;
        end
    end

    // Remember who won last so contention alternates
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= OWN_B;
        end else if (gnt_a) begin
            last_grant <= OWN_A;
        end else if (gnt_b) begin
            last_grant <= OWN_B;
        end
    end

    // Track a granted read until the RAM returns its data
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_A;
        end else begin
            rd_pend <= (gnt_a && !we_a) || (gnt_b && !we_b);
            if (gnt_a || gnt_b) begin
                rd_owner <= gnt_b ? OWN_B : OWN_A;
            end
        end
    end

    // Keep the last returned word per requester for the hold value
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else if (rd_pend) begin
            if (rd_owner == OWN_A) begin
                rdata_a_q <= ram_q;
            end else begin
                rdata_b_q <= ram_q;
            end
        end
    end

    assign rvalid_a = !reset && rd_pend && (rd_owner == OWN_A);
    assign rvalid_b = !reset && rd_pend && (rd_owner == OWN_B);
    assign rdata_a  = rvalid_a ? ram_q : rdata_a_q;
    assign rdata_b  = rvalid_b ? ram_q : rdata_b_q;

endmodule
